// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   NIBBLE    : width of the time-shared lookahead slice
//   idx_width : bit width needed to count the nibble index
package cla_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;

  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_add_slice4.sv
// Purely combinational 4-bit carry-lookahead slice.
//   x, y : nibble operands
//   ci   : carry into bit 0
//   s    : nibble sum
//   c3   : carry into bit 3 (used for signed overflow)
//   c4   : carry out of bit 3
module add_slice4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is expanded directly from generate/propagate terms,
  // so no carry depends on a previous carry.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder that steps one 4-bit lookahead slice through
// WIDTH/4 nibbles, LSB first, carrying between steps in a register.
//   clk, rst_n             : clock, async active-low reset
//   in_valid/in_ready      : operand handshake (a, b, cin [, sub])
//   out_valid/out_ready    : result handshake (sum, cout, ovf)
//   busy                   : high while in RUN or DONE
// Optional macro CLA_SEQ_SUB_EN adds the 'sub' input (a - b when set).
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble per cycle through the slice
// DONE  | result presented until out_ready
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / NIBBLE;
  localparam int IW     = idx_width(NSLICE);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last;
  logic             sub_eff;
  logic [3:0]       s_nib;
  logic             c3;
  logic             c4;

`ifdef CLA_SEQ_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign last = (idx == IW'(NSLICE - 1));

  // Operand registers shift right each RUN cycle, so the slice always
  // sees the current nibble in bits [3:0].
  add_slice4 u_slice (
    .x  (a_reg[3:0]),
    .y  (b_reg[3:0]),
    .ci (carry),
    .s  (s_nib),
    .c3 (c3),
    .c4 (c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= sub_eff ? ~b : b;
            carry <= sub_eff ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          a_reg <= a_reg >> NIBBLE;
          b_reg <= b_reg >> NIBBLE;
          carry <= c4;
          idx   <= idx + IW'(1);
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IW'(i)) sum[i*NIBBLE +: NIBBLE] <= s_nib;
          end
          if (last) begin
            cout <= c4;
            ovf  <= c3 ^ c4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
